// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - sequential AES SubBytes engine, LANES bytes per clock (inverse S-box under SUBBYTES_INV_EN)
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Entry 0 sits in the most significant byte of each table.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [127:0]   work, work_sub;
    logic [CW-1:0]  cnt;
    logic           load, step, last;
    int             base;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_out [LANES];

`ifdef SUBBYTES_INV_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    logic inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    assign base = int'(cnt) * LANES;
    assign last = (cnt == CW'(NCHUNK - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = work[8*(base+g) +: 8];
`ifdef SUBBYTES_INV_EN
        assign lane_out[g] = inv ? SBOX_INV[2047 - 8*int'(lane_in[g]) -: 8]
                                 : SBOX_FWD[2047 - 8*int'(lane_in[g]) -: 8];
`else
        assign lane_out[g] = SBOX_FWD[2047 - 8*int'(lane_in[g]) -: 8];
`endif
    end

    always_comb begin
        work_sub = work;
        for (int j = 0; j < LANES; j++) begin
            work_sub[8*(base+j) +: 8] = lane_out[j];
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Downstream acceptance frees the work register for a new block on the same edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
`ifdef SUBBYTES_INV_EN
            inv   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (load) begin
                work <= in_state;
                cnt  <= '0;
`ifdef SUBBYTES_INV_EN
                inv  <= in_inv;
`endif
            end else if (step) begin
                work <= work_sub;
                cnt  <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign out_state = work;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - randomized self-checking bench for sub_bytes_seq at LANES 1, 2, 4, 16
module tb_sub_bytes_seq;
`ifdef SUBBYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_state  [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_state [4];
    logic         busy      [4];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] fsb [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sub_bytes_seq #(.LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    function automatic int nchunk(input int d);
        return (d == 0) ? 16 : (d == 1) ? 8 : (d == 2) ? 4 : 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] t = {x, x} << k;
        return t[15:8];
    endfunction

    // S(x) = affine(x^-1) over GF(2^8); the inverse table is its reverse mapping.
    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] r = 8'h01;
            logic [7:0] b = 8'(x);
            if (x == 0) r = 8'h00;
            else for (int e = 0; e < 254; e++) r = gmul(r, b);
            fsb[x] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[fsb[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = (inv && INV_EN) ? isb[s[8*i +: 8]] : fsb[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int d, input logic [127:0] s, input logic inv);
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_state[d] = s;
        in_inv[d]   = inv;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int n, output int nb);
        n = 0;
        nb = 0;
        while (!out_valid[d] && n < 64) begin
            if (busy[d]) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            in_valid[d] = 1'b0; in_state[d] = '0; in_inv[d] = 1'b0; out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors += 4;
            if (out_valid[d] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid d=%0d got %b want 0", d, out_valid[d]); end
            if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL reset_busy d=%0d got %b want 0", d, busy[d]); end
            if (in_ready[d] !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready d=%0d got %b want 1", d, in_ready[d]); end
            if (out_state[d] !== 128'h0) begin miscompares++; $display("FAIL reset_out_state d=%0d got %h want 0", d, out_state[d]); end
        end
    endtask

    task automatic test_zero_state();
        int n, nb;
        send(2, 128'h0, 1'b0);
        wait_done(2, n, nb);
        vectors += 3;
        if (n !== 4) begin miscompares++; $display("FAIL zero_latency got %0d want 4", n); end
        if (nb !== 4) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want 4", nb); end
        if (out_state[2] !== {16{8'h63}}) begin miscompares++; $display("FAIL zero_data got %h want %h", out_state[2], {16{8'h63}}); end
    endtask

    task automatic test_byte_order();
        int n, nb;
        logic [127:0] s, exp;
        for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(i);
        s[127:120] = 8'hff;
        exp = ref_sub(s, 1'b0);
        send(0, s, 1'b0);
        wait_done(0, n, nb);
        vectors += 5;
        if (n !== 16) begin miscompares++; $display("FAIL order_latency got %0d want 16", n); end
        if (out_state[0] !== exp) begin miscompares++; $display("FAIL order_data got %h want %h", out_state[0], exp); end
        if (out_state[0][7:0] !== 8'h63) begin miscompares++; $display("FAIL order_byte0 got %h want 63", out_state[0][7:0]); end
        if (out_state[0][15:8] !== 8'h7c) begin miscompares++; $display("FAIL order_byte1 got %h want 7c", out_state[0][15:8]); end
        if (out_state[0][127:120] !== 8'h16) begin miscompares++; $display("FAIL order_byte15 got %h want 16", out_state[0][127:120]); end
    endtask

    task automatic test_inverse_single_cycle();
        int n, nb;
        logic [127:0] exp = INV_EN ? {16{8'h53}} : {16{8'h55}};
        send(3, {16{8'hed}}, 1'b1);
        wait_done(3, n, nb);
        vectors += 2;
        if (n !== 1) begin miscompares++; $display("FAIL inv16_latency got %0d want 1", n); end
        if (out_state[3] !== exp) begin miscompares++; $display("FAIL inv16_data got %h want %h", out_state[3], exp); end
    endtask

    task automatic test_backpressure();
        int n, nb;
        logic [127:0] s = rand128();
        logic [127:0] exp = ref_sub(s, 1'b0);
        out_ready[2] = 1'b0;
        send(2, s, 1'b0);
        wait_done(2, n, nb);
        vectors += 2;
        if (n !== 4) begin miscompares++; $display("FAIL bp_latency got %0d want 4", n); end
        if (out_state[2] !== exp) begin miscompares++; $display("FAIL bp_data got %h want %h", out_state[2], exp); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors += 3;
            if (out_valid[2] !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", c, out_valid[2]); end
            if (out_state[2] !== exp) begin miscompares++; $display("FAIL bp_hold_data cyc=%0d got %h want %h", c, out_state[2], exp); end
            if (in_ready[2] !== 1'b0) begin miscompares++; $display("FAIL bp_hold_in_ready cyc=%0d got %b want 0", c, in_ready[2]); end
        end
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_state[2]  = {16{8'h53}};
        in_inv[2]    = 1'b0;
        #1;
        vectors++;
        if (in_ready[2] !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got %b want 1", in_ready[2]); end
        @(negedge clk);
        in_valid[2] = 1'b0;
        vectors += 2;
        if (out_valid[2] !== 1'b0) begin miscompares++; $display("FAIL bp_consumed_valid got %b want 0", out_valid[2]); end
        if (busy[2] !== 1'b1) begin miscompares++; $display("FAIL bp_chained_busy got %b want 1", busy[2]); end
        wait_done(2, n, nb);
        vectors += 2;
        if (n !== 4) begin miscompares++; $display("FAIL bp_chained_latency got %0d want 4", n); end
        if (out_state[2] !== ref_sub({16{8'h53}}, 1'b0)) begin miscompares++; $display("FAIL bp_chained_data got %h want %h", out_state[2], {16{8'hed}}); end
    endtask

    task automatic test_reset_mid_run();
        int n, nb;
        logic [127:0] s = rand128();
        send(1, rand128(), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (out_valid[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", out_valid[1]); end
        if (busy[1] !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy[1]); end
        if (in_ready[1] !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got %b want 1", in_ready[1]); end
        if (out_state[1] !== 128'h0) begin miscompares++; $display("FAIL midrst_state got %h want 0", out_state[1]); end
        rst = 1'b0;
        send(1, s, 1'b0);
        wait_done(1, n, nb);
        vectors += 2;
        if (n !== 8) begin miscompares++; $display("FAIL midrst_fresh_latency got %0d want 8", n); end
        if (out_state[1] !== ref_sub(s, 1'b0)) begin miscompares++; $display("FAIL midrst_fresh_data got %h want %h", out_state[1], ref_sub(s, 1'b0)); end
    endtask

    task automatic test_input_toggle();
        int n, nb;
        logic [127:0] s = rand128();
        logic inv = 1'b1;
        send(2, s, inv);
        for (int c = 0; c < 3; c++) begin
            in_inv[2] = ~in_inv[2];
            in_state[2] = rand128();
            @(negedge clk);
        end
        wait_done(2, n, nb);
        vectors += 2;
        if (n + 3 !== 4) begin miscompares++; $display("FAIL toggle_latency got %0d want 4", n + 3); end
        if (out_state[2] !== ref_sub(s, inv)) begin miscompares++; $display("FAIL toggle_data got %h want %h", out_state[2], ref_sub(s, inv)); end
    endtask

    task automatic test_random_blocks();
        int n, nb;
        for (int d = 0; d < 4; d++) begin
            for (int b = 0; b < 12; b++) begin
                logic [127:0] s = rand128();
                logic inv = 1'($urandom_range(0, 1));
                send(d, s, inv);
                wait_done(d, n, nb);
                vectors += 2;
                if (n !== nchunk(d)) begin miscompares++; $display("FAIL rand_latency d=%0d blk=%0d got %0d want %0d", d, b, n, nchunk(d)); end
                if (out_state[d] !== ref_sub(s, inv)) begin miscompares++; $display("FAIL rand_data d=%0d blk=%0d inv=%b got %h want %h", d, b, inv, out_state[d], ref_sub(s, inv)); end
            end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_zero_state();
        test_byte_order();
        test_inverse_single_cycle();
        test_backpressure();
        test_reset_mid_run();
        test_input_toggle();
        test_random_blocks();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
